lsu_ctrl: RTL

Load/store controller sitting directly upstream of the 8-bit x 256 data memory; owns every memory address, write-data and write-enable signal. Accepts byte loads/stores, stack push/pop and two-cycle 16-bit pair accesses from the execute stage via a valid/ready handshake. Maintains the stack pointer and returns registered read data one cycle after each access completes.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_ctrl_if.sv | 23 ++
 rtl/lsu_stack_ptr.sv | 43 ++++
 rtl/lsu_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store controller.
// Optional build macro: LSU_ALIGN_CHECK_EN (rejects odd-address pair ops).
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LOAD   = 3'b000,
      OP_STORE  = 3'b001,
      OP_PUSH   = 3'b010,
      OP_POP    = 3'b011,
      OP_LOADP  = 3'b100,
      OP_STOREP = 3'b101
   } op_t;

   typedef enum logic {
      ST_IDLE,
      ST_SECOND
   } state_t;

   localparam logic [7:0] SP_INIT_DEF  = 8'hFF;
   localparam logic [7:0] SP_LIMIT_DEF = 8'hC0;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-stage request / response handshake bundle.
interface lsu_ctrl_if;

   logic        req_valid;
   logic [2:0]  req_op;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/lsu_stack_ptr.sv
// Empty-descending stack pointer with overflow/underflow flags.
module lsu_stack_ptr
   import lsu_pkg::*;
#(
   parameter logic [7:0] SP_INIT  = SP_INIT_DEF,
   parameter logic [7:0] SP_LIMIT = SP_LIMIT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   output logic [7:0] sp,
   output logic [7:0] sp_inc,
   output logic       ovf,
   output logic       unf
);

   logic [7:0] sp_q;
   logic [7:0] sp_d;

   assign sp     = sp_q;
   assign sp_inc = sp_q + 8'd1;
   assign ovf    = (sp_q == SP_LIMIT);
   assign unf    = (sp_q == SP_INIT);

   always_comb begin
      sp_d = sp_q;
      if (push && !ovf) begin
         sp_d = sp_q - 8'd1;
      end else if (pop && !unf) begin
         sp_d = sp_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= SP_INIT;
      end else begin
         sp_q <= sp_d;
      end
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of the 8-bit x 256 data memory.
// Define LSU_ALIGN_CHECK_EN to reject LOADP/STOREP at odd addresses.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter logic [7:0] SP_INIT  = SP_INIT_DEF,
   parameter logic [7:0] SP_LIMIT = SP_LIMIT_DEF
) (
   input  logic         clk,
   input  logic         reset,
   lsu_ctrl_if.slave    bus,
   output logic [7:0]   sp,
   output logic [7:0]   mem_addr,
   output logic [7:0]   mem_dat_in,
   output logic         mem_wr_en,
   input  logic [7:0]   mem_dat_out
);

   state_t      state_q, state_d;
   logic        pair_st_q, pair_st_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  whi_q, whi_d;
   logic [7:0]  lo_q, lo_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [15:0] rsp_rdata_q, rsp_rdata_d;

   logic        accept;
   logic        push, pop;
   logic        ovf, unf;
   logic        wr;
   logic        align_err;
   logic [7:0]  sp_inc;

   lsu_stack_ptr #(
      .SP_INIT  (SP_INIT),
      .SP_LIMIT (SP_LIMIT)
   ) u_sp (
      .clk    (clk),
      .reset  (reset),
      .push   (push),
      .pop    (pop),
      .sp     (sp),
      .sp_inc (sp_inc),
      .ovf    (ovf),
      .unf    (unf)
   );

`ifdef LSU_ALIGN_CHECK_EN
   assign align_err = bus.req_addr[0];
`else
   assign align_err = 1'b0;
`endif

   assign bus.req_ready = (state_q == ST_IDLE) && !reset;
   assign accept        = bus.req_valid && bus.req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   // A write left pending in SECOND must not land while reset is held.
   assign mem_wr_en     = wr && !reset;

   always_comb begin
      state_d     = state_q;
      pair_st_d   = pair_st_q;
      addr_d      = addr_q;
      whi_d       = whi_q;
      lo_d        = lo_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 16'h0000;
      mem_addr    = 8'h00;
      mem_dat_in  = 8'h00;
      wr          = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;

      if (state_q == ST_SECOND) begin
         state_d     = ST_IDLE;
         rsp_valid_d = 1'b1;
         mem_addr    = addr_q + 8'd1;
         if (pair_st_q) begin
            mem_dat_in = whi_q;
            wr         = 1'b1;
         end else begin
            rsp_rdata_d = {mem_dat_out, lo_q};
         end
      end else if (accept) begin
         rsp_valid_d = 1'b1;
         unique case (bus.req_op)
            OP_LOAD: begin
               mem_addr    = bus.req_addr;
               rsp_rdata_d = {8'h00, mem_dat_out};
            end
            OP_STORE: begin
               mem_addr   = bus.req_addr;
               mem_dat_in = bus.req_wdata[7:0];
               wr         = 1'b1;
            end
            OP_PUSH: begin
               if (ovf) begin
                  rsp_err_d = 1'b1;
               end else begin
                  mem_addr   = sp;
                  mem_dat_in = bus.req_wdata[7:0];
                  wr         = 1'b1;
                  push       = 1'b1;
               end
            end
            OP_POP: begin
               if (unf) begin
                  rsp_err_d = 1'b1;
               end else begin
                  mem_addr    = sp_inc;
                  rsp_rdata_d = {8'h00, mem_dat_out};
                  pop         = 1'b1;
               end
            end
            OP_LOADP, OP_STOREP: begin
               if (align_err) begin
                  rsp_err_d = 1'b1;
               end else begin
                  // Response is deferred until the high byte is done.
                  rsp_valid_d = 1'b0;
                  state_d     = ST_SECOND;
                  mem_addr    = bus.req_addr;
                  addr_d      = bus.req_addr;
                  whi_d       = bus.req_wdata[15:8];
                  pair_st_d   = (bus.req_op == OP_STOREP);
                  if (bus.req_op == OP_STOREP) begin
                     mem_dat_in = bus.req_wdata[7:0];
                     wr         = 1'b1;
                  end else begin
                     lo_d = mem_dat_out;
                  end
               end
            end
            default: begin
               rsp_err_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pair_st_q   <= 1'b0;
         addr_q      <= 8'h00;
         whi_q       <= 8'h00;
         lo_q        <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         pair_st_q   <= pair_st_d;
         addr_q      <= addr_d;
         whi_q       <= whi_d;
         lo_q        <= lo_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

endmodule
